// File: rtl/blossom_scheduler_if.sv
// Click handshake bundle between the mouse front end and the blossom scheduler.
// The master raises click_req with a stable coordinate; the scheduler answers
// with click_ack plus the hit result, four-phase.
interface blossom_scheduler_if;
  logic       click_req;
  logic [9:0] click_x;
  logic [9:0] click_y;
  logic       click_ack;
  logic       click_hit;
  logic [2:0] click_idx;

  modport master (
    output click_req, click_x, click_y,
    input  click_ack, click_hit, click_idx
  );

  modport slave (
    input  click_req, click_x, click_y,
    output click_ack, click_hit, click_idx
  );
endinterface

// File: rtl/blossom_scheduler.sv
// Falling-blossom state controller for the VGA tree demo. Holds per-blossom
// y/visibility/respawn state and walks one blossom per cycle through a shared
// compare/add unit, either for the per-frame motion pass or for a click test.
module blossom_scheduler #(
  parameter int NUM_BLOSSOMS   = 8,
  parameter int X_BASE         = 305,
  parameter int X_STEP         = 5,
  parameter int START_Y        = 240,
  parameter int FLOOR_Y        = 480,
  parameter int SIZE           = 5,
  parameter int SPAWN_GAP      = 16,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  blossom_scheduler_if.slave          click,
  output logic [10*NUM_BLOSSOMS-1:0]  blossom_x,
  output logic [10*NUM_BLOSSOMS-1:0]  blossom_y,
  output logic [NUM_BLOSSOMS-1:0]     blossom_vis,
  output logic [7:0]                  score,
  output logic                        busy,
  output logic                        overrun
);

  typedef enum logic [1:0] {IDLE, UPDATE, CLICK, ACK} state_t;

  localparam logic [2:0] LAST_IDX = 3'(NUM_BLOSSOMS - 1);

  state_t      state_reg, state_next;
  logic [2:0]  idx_reg, idx_next;
  logic        hit_found_reg, hit_found_next;
  logic [2:0]  hit_idx_reg, hit_idx_next;
  logic        click_ack_reg, click_ack_next;
  logic        click_hit_reg, click_hit_next;
  logic [2:0]  click_idx_reg, click_idx_next;
  logic [7:0]  score_reg, score_next;
  logic        tick_pend_reg, tick_pend_next;
  logic        overrun_reg, overrun_next;
  logic        enter_update;

  // Write port into the blossom currently addressed by idx_reg
  logic        wr_en;
  logic [9:0]  wr_y;
  logic        wr_vis;
  logic [6:0]  wr_cnt;

  logic [7*NUM_BLOSSOMS-1:0] cnt_flat;

  // Shared compare/add unit operands for the addressed blossom
  logic [9:0]  cur_y;
  logic        cur_vis;
  logic [6:0]  cur_cnt;
  logic [10:0] cur_x, cur_y11, pt_x, pt_y;
  logic        hit_now;

  assign cur_y   = blossom_y[10*idx_reg +: 10];
  assign cur_vis = blossom_vis[idx_reg];
  assign cur_cnt = cnt_flat[7*idx_reg +: 7];
  assign cur_x   = 11'(X_BASE) + 11'(X_STEP) * {8'd0, idx_reg};
  assign cur_y11 = {1'b0, cur_y};
  assign pt_x    = {1'b0, click.click_x};
  assign pt_y    = {1'b0, click.click_y};
  assign hit_now = cur_vis &&
                   (pt_x >= cur_x)   && (pt_x < cur_x + 11'(SIZE)) &&
                   (pt_y >= cur_y11) && (pt_y < cur_y11 + 11'(SIZE));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BLOSSOMS; gi++) begin : g_blossom
      logic [9:0] y_reg;
      logic       vis_reg;
      logic [6:0] cnt_reg;
      logic       sel;

      assign sel = wr_en && (idx_reg == 3'(gi));

      // Per-blossom state; only the addressed blossom is written each cycle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          y_reg   <= 10'(START_Y);
          vis_reg <= 1'b0;
          cnt_reg <= 7'(gi * SPAWN_GAP);
        end else if (sel) begin
          y_reg   <= wr_y;
          vis_reg <= wr_vis;
          cnt_reg <= wr_cnt;
        end
      end

      assign blossom_x[10*gi +: 10] = 10'(X_BASE + gi * X_STEP);
      assign blossom_y[10*gi +: 10] = y_reg;
      assign blossom_vis[gi]        = vis_reg;
      assign cnt_flat[7*gi +: 7]    = cnt_reg;
    end
  endgenerate

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= 3'd0;
      hit_found_reg <= 1'b0;
      hit_idx_reg   <= 3'd0;
      click_ack_reg <= 1'b0;
      click_hit_reg <= 1'b0;
      click_idx_reg <= 3'd0;
      score_reg     <= 8'd0;
      tick_pend_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      hit_found_reg <= hit_found_next;
      hit_idx_reg   <= hit_idx_next;
      click_ack_reg <= click_ack_next;
      click_hit_reg <= click_hit_next;
      click_idx_reg <= click_idx_next;
      score_reg     <= score_next;
      tick_pend_reg <= tick_pend_next;
      overrun_reg   <= overrun_next;
    end
  end

  // Next-state, blossom write port and handshake outputs
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    hit_found_next = hit_found_reg;
    hit_idx_next   = hit_idx_reg;
    click_ack_next = click_ack_reg;
    click_hit_next = click_hit_reg;
    click_idx_next = click_idx_reg;
    score_next     = score_reg;
    enter_update   = 1'b0;
    wr_en          = 1'b0;
    wr_y           = cur_y;
    wr_vis         = cur_vis;
    wr_cnt         = cur_cnt;

    case (state_reg)
      IDLE: begin
        // A tick arriving this very cycle counts as pending so motion wins a tie
        if (tick_pend_reg || frame_tick) begin
          state_next   = UPDATE;
          idx_next     = 3'd0;
          enter_update = 1'b1;
        end else if (click.click_req && !click_ack_reg) begin
          state_next     = CLICK;
          idx_next       = 3'd0;
          hit_found_next = 1'b0;
          hit_idx_next   = 3'd0;
        end
      end

      UPDATE: begin
        wr_en = 1'b1;
        if (cur_vis) begin
          if (cur_y >= 10'(FLOOR_Y - 1)) wr_y = 10'(START_Y);
          else                           wr_y = cur_y + 10'd1;
        end else if (cur_cnt == 7'd0) begin
          wr_vis = 1'b1;
          wr_y   = 10'(START_Y);
        end else begin
          wr_cnt = cur_cnt - 7'd1;
        end
        if (idx_reg == LAST_IDX) state_next = IDLE;
        else                     idx_next   = idx_reg + 3'd1;
      end

      CLICK: begin
        // Only the lowest-index hit of a pass removes a blossom
        if (hit_now && !hit_found_reg) begin
          wr_en          = 1'b1;
          wr_vis         = 1'b0;
          wr_cnt         = 7'(RESPAWN_FRAMES);
          hit_found_next = 1'b1;
          hit_idx_next   = idx_reg;
          if (score_reg != 8'hFF) score_next = score_reg + 8'd1;
        end
        if (idx_reg == LAST_IDX) begin
          state_next     = ACK;
          click_ack_next = 1'b1;
          click_hit_next = hit_found_next;
          click_idx_next = hit_idx_next;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end

      ACK: begin
        if (!click.click_req) begin
          state_next     = IDLE;
          click_ack_next = 1'b0;
          click_hit_next = 1'b0;
          click_idx_next = 3'd0;
        end
      end

      default: state_next = IDLE;
    endcase

    // Entering UPDATE consumes the pending tick; a tick on top of a pending one is lost
    if (enter_update)    tick_pend_next = 1'b0;
    else if (frame_tick) tick_pend_next = 1'b1;
    else                 tick_pend_next = tick_pend_reg;
    overrun_next = overrun_reg | (frame_tick & tick_pend_reg);
  end

  assign click.click_ack = click_ack_reg;
  assign click.click_hit = click_hit_reg;
  assign click.click_idx = click_idx_reg;
  assign score           = score_reg;
  assign overrun         = overrun_reg;
  assign busy            = (state_reg != IDLE);

endmodule

// File: tb/tb_blossom_scheduler.sv
// Directed bench for blossom_scheduler: motion, wrap, respawn, click hit/miss,
// lowest-index priority, tick/click arbitration, overrun and async reset.
module tb_blossom_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;

  always #5 clk = ~clk;

  blossom_scheduler_if if1();
  blossom_scheduler_if if2();

  logic [79:0] x_1, y_1, x_2, y_2;
  logic [7:0]  vis_1, vis_2, score_1, score_2;
  logic        busy_1, busy_2, ovr_1, ovr_2;

  blossom_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .click(if1.slave),
    .blossom_x(x_1), .blossom_y(y_1), .blossom_vis(vis_1),
    .score(score_1), .busy(busy_1), .overrun(ovr_1)
  );

  // Second instance with overlapping blossoms, all spawned on the first tick
  blossom_scheduler #(.X_STEP(2), .SPAWN_GAP(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .click(if2.slave),
    .blossom_x(x_2), .blossom_y(y_2), .blossom_vis(vis_2),
    .score(score_2), .busy(busy_2), .overrun(ovr_2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic logic [9:0] y1(input int i);
    return y_1[10*i +: 10];
  endfunction

  task automatic do_tick();
    int n;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    n = 0;
    while (busy_1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy_1) check("tick_timeout", 32'(busy_1), 32'd0);
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) do_tick();
  endtask

  task automatic do_click(input int which, input logic [9:0] cx, input logic [9:0] cy,
                          output int lat, output logic hit, output logic [2:0] idx);
    logic ackv;
    @(negedge clk);
    if (which == 0) begin if1.click_x = cx; if1.click_y = cy; if1.click_req = 1'b1; end
    else            begin if2.click_x = cx; if2.click_y = cy; if2.click_req = 1'b1; end
    lat = 0;
    ackv = 1'b0;
    while (!ackv && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      ackv = (which == 0) ? if1.click_ack : if2.click_ack;
    end
    if (!ackv) check("ack_timeout", 32'(ackv), 32'd1);
    hit = (which == 0) ? if1.click_hit : if2.click_hit;
    idx = (which == 0) ? if1.click_idx : if2.click_idx;
    @(negedge clk);
    if (which == 0) if1.click_req = 1'b0; else if2.click_req = 1'b0;
    @(posedge clk); #1;
    ackv = (which == 0) ? if1.click_ack : if2.click_ack;
    check("ack_drop", 32'(ackv), 32'd0);
  endtask

  int          lat;
  logic        hit;
  logic [2:0]  idx;
  logic        seen;

  initial begin
    if1.click_req = 1'b0; if1.click_x = '0; if1.click_y = '0;
    if2.click_req = 1'b0; if2.click_x = '0; if2.click_y = '0;

    repeat (3) @(negedge clk);
    check("rst_y0", 32'(y1(0)), 32'd240);
    check("rst_y7", 32'(y1(7)), 32'd240);
    check("rst_vis", 32'(vis_1), 32'd0);
    check("rst_score", 32'(score_1), 32'd0);
    check("rst_ack", 32'(if1.click_ack), 32'd0);
    check("rst_ovr", 32'(ovr_1), 32'd0);
    check("rst_busy", 32'(busy_1), 32'd0);
    check("x_slot0", 32'(x_1[9:0]), 32'd305);
    check("x_slot3", 32'(x_1[39:30]), 32'd320);
    rst_n = 1'b1;

    // Tick 1: only blossom 0 spawns
    do_tick();
    check("t1_vis", 32'(vis_1), 32'h01);
    check("t1_y0", 32'(y1(0)), 32'd240);

    // Overlap: blossoms 0 and 1 of the second instance both cover (307,241)
    check("ov_vis", 32'(vis_2), 32'hFF);
    do_click(1, 10'd307, 10'd241, lat, hit, idx);
    check("ov1_lat", 32'(lat), 32'd9);
    check("ov1_hit", 32'(hit), 32'd1);
    check("ov1_idx", 32'(idx), 32'd0);
    check("ov1_vis", 32'(vis_2), 32'hFE);
    do_click(1, 10'd307, 10'd241, lat, hit, idx);
    check("ov2_idx", 32'(idx), 32'd1);
    check("ov2_vis", 32'(vis_2), 32'hFC);
    check("ov2_score", 32'(score_2), 32'd2);

    run_ticks(15);                            // tick 16
    check("t16_vis", 32'(vis_1), 32'h01);
    do_tick();                                // tick 17
    check("t17_vis", 32'(vis_1), 32'h03);
    check("t17_y0", 32'(y1(0)), 32'd256);

    run_ticks(92);                            // tick 109
    check("t109_vis", 32'(vis_1), 32'h7F);
    check("t109_y3", 32'(y1(3)), 32'd300);

    do_click(0, 10'd322, 10'd302, lat, hit, idx);
    check("hit_lat", 32'(lat), 32'd9);
    check("hit_hit", 32'(hit), 32'd1);
    check("hit_idx", 32'(idx), 32'd3);
    check("hit_vis", 32'(vis_1), 32'h77);
    check("hit_score", 32'(score_1), 32'd1);

    do_click(0, 10'd0, 10'd0, lat, hit, idx);
    check("miss_hit", 32'(hit), 32'd0);
    check("miss_idx", 32'(idx), 32'd0);
    check("miss_score", 32'(score_1), 32'd1);

    run_ticks(60);                            // tick 169
    check("resp60_vis3", 32'(vis_1[3]), 32'd0);
    do_tick();                                // tick 170
    check("resp61_vis3", 32'(vis_1[3]), 32'd1);
    check("resp61_y3", 32'(y1(3)), 32'd240);

    run_ticks(69);                            // tick 239
    check("t239_y0", 32'(y1(0)), 32'd478);
    do_tick();
    check("t240_y0", 32'(y1(0)), 32'd479);
    do_tick();
    check("wrap_y0", 32'(y1(0)), 32'd240);
    check("wrap_vis0", 32'(vis_1[0]), 32'd1);

    // Tick and click on the same cycle: full UPDATE pass, then the click
    @(negedge clk);
    frame_tick = 1'b1;
    if1.click_x = 10'd0; if1.click_y = 10'd0; if1.click_req = 1'b1;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      frame_tick = 1'b0;
      lat++;
      seen = if1.click_ack;
    end
    check("both_lat", 32'(lat), 32'd18);
    check("both_y0", 32'(y1(0)), 32'd241);
    @(negedge clk) if1.click_req = 1'b0;
    repeat (2) @(negedge clk);

    // Two further ticks inside one UPDATE pass
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("ovr_one", 32'(ovr_1), 32'd0);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    check("ovr_two", 32'(ovr_1), 32'd1);
    begin
      int n;
      n = 0;
      while (busy_1 && n < 60) begin @(negedge clk); n++; end
      if (busy_1) check("ovr_timeout", 32'(busy_1), 32'd0);
    end

    // Reset pulse in the middle of a click pass
    @(negedge clk);
    if1.click_x = 10'd322; if1.click_y = 10'd250; if1.click_req = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy_1), 32'd0);
    check("mid_vis", 32'(vis_1), 32'd0);
    check("mid_score", 32'(score_1), 32'd0);
    check("mid_ovr", 32'(ovr_1), 32'd0);
    check("mid_y0", 32'(y1(0)), 32'd240);
    if1.click_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      seen = seen | if1.click_ack;
    end
    check("mid_no_ack", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
